uart_bist_ctrl: RTL and testbench

UART_BIST_CTRL -- requirements
Module: uart_bist_ctrl

---
 rtl/uart_bist_pkg.sv | 33 +++
 rtl/uart_bist_pattern.sv | 23 ++
 rtl/uart_bist_ctrl.sv | 139 +++++++++++++
 tb/tb_uart_bist_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bist_pkg.sv
// Shared state encoding and pattern constants for the UART loopback BIST.
// Define UART_BIST_LFSR_EN for an LFSR pattern; the default is a byte counter.
package uart_bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_RX = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } bist_state_t;

`ifdef UART_BIST_LFSR_EN
  localparam logic [7:0] PATTERN_SEED = 8'h01;
  // Fibonacci taps on bits 7,5,4,3; feedback enters at bit 0.
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
`else
  localparam logic [7:0] PATTERN_SEED = 8'h00;
`endif

  function automatic logic [7:0] pattern_next(input logic [7:0] p);
`ifdef UART_BIST_LFSR_EN
    pattern_next = {p[6:0], ^(p & LFSR_TAPS)};
`else
    pattern_next = p + 8'd1;
`endif
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_bist_pattern.sv
// Test pattern register: reloads the seed on load, advances one step on step.
// Sequence selected by UART_BIST_LFSR_EN through uart_bist_pkg.
module uart_bist_pattern
  import uart_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  output logic [7:0] pattern
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= PATTERN_SEED;
    end else if (load) begin
      pattern <= PATTERN_SEED;
    end else if (step) begin
      pattern <= pattern_next(pattern);
    end
  end

endmodule

// File: rtl/uart_bist_ctrl.sv
// UART loopback BIST controller: sends NUM_BYTES patterns, checks the echoes,
// counts mismatches and receive timeouts. Pattern type set by UART_BIST_LFSR_EN.
module uart_bist_ctrl
  import uart_bist_pkg::*;
#(
  parameter int NUM_BYTES      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       tx_busy,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       timeout_err
);

  localparam int                 TIMER_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]         LAST_BYTE  = 8'(NUM_BYTES - 1);

  bist_state_t        state;
  logic [7:0]         byte_cnt;
  logic [7:0]         rx_byte;
  logic [7:0]         pattern;
  logic [7:0]         err_next;
  logic [TIMER_W-1:0] timer;
  logic               in_run;
  logic               kill;
  logic               rx_timeout;
  logic               advance;
  logic               err_inc;
  logic               last_byte;
  logic               pat_load;
  logic               pat_step;

  // A byte finishes either by a timeout in WAIT_RX or by its CHECK cycle.
  always_comb begin
    in_run     = (state == SEND) || (state == WAIT_RX) || (state == CHECK);
    kill       = abort && in_run;
    rx_timeout = (state == WAIT_RX) && !rx_done && (timer == TIMER_LAST);
    advance    = rx_timeout || (state == CHECK);
    err_inc    = rx_timeout || ((state == CHECK) && (rx_byte != pattern));
    err_next   = err_inc ? sat_inc(err_count) : err_count;
    last_byte  = (byte_cnt == LAST_BYTE);
    pat_load   = ((state == IDLE) || (state == DONE)) && start;
    pat_step   = advance && !last_byte && !kill;
  end

  uart_bist_pattern u_pattern (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pat_load),
    .step    (pat_step),
    .pattern (pattern)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= 8'h00;
      timeout_err <= 1'b0;
      byte_cnt    <= 8'h00;
      timer       <= '0;
      rx_byte     <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      if (kill) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        err_count <= err_next;
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state       <= SEND;
              busy        <= 1'b1;
              done        <= 1'b0;
              pass        <= 1'b0;
              byte_cnt    <= 8'h00;
              err_count   <= 8'h00;
              timeout_err <= 1'b0;
            end
          end
          SEND: begin
            if (!tx_busy) begin
              tx_start <= 1'b1;
              tx_data  <= pattern;
              timer    <= '0;
              state    <= WAIT_RX;
            end
          end
          WAIT_RX: begin
            if (rx_done) begin
              rx_byte <= rx_data;
              state   <= CHECK;
            end else if (timer == TIMER_LAST) begin
              timeout_err <= 1'b1;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          CHECK: begin
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
        // pass is latched from the final count so it is valid the same cycle done rises.
        if (advance) begin
          if (last_byte) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 8'h00);
          end else begin
            byte_cnt <= byte_cnt + 8'd1;
            state    <= SEND;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_bist_ctrl.sv
// Scoreboard bench for uart_bist_ctrl with a randomized UART loopback responder.
// Follows UART_BIST_LFSR_EN for the expected pattern sequence.
module tb_uart_bist_ctrl;

  localparam int NB     = 4;
  localparam int TO     = 32;
  localparam int SAT_NB = 256;
  localparam int SAT_TO = 4;

  localparam int M_GOOD    = 0;
  localparam int M_CORRUPT = 1;
  localparam int M_DROP    = 2;
  localparam int M_EDGE    = 3;
  localparam int M_LATE    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       resp_busy = 1'b0;
  logic       hold_busy = 1'b0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic       timeout_err;

  logic       sat_start = 1'b0;
  logic       sat_tx_start;
  logic [7:0] sat_tx_data;
  logic       sat_busy;
  logic       sat_done;
  logic       sat_pass;
  logic [7:0] sat_err_count;
  logic       sat_timeout_err;

  assign tx_busy = resp_busy | hold_busy;

  always #5 clk = ~clk;

  uart_bist_ctrl #(.NUM_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tx_busy(tx_busy),
    .rx_done(rx_done), .rx_data(rx_data), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .timeout_err(timeout_err)
  );

  uart_bist_ctrl #(.NUM_BYTES(SAT_NB), .TIMEOUT_CYCLES(SAT_TO)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(sat_start), .abort(1'b0), .tx_busy(1'b0),
    .rx_done(1'b0), .rx_data(8'h00), .tx_start(sat_tx_start), .tx_data(sat_tx_data),
    .busy(sat_busy), .done(sat_done), .pass(sat_pass), .err_count(sat_err_count),
    .timeout_err(sat_timeout_err)
  );

  typedef struct packed {
    logic [7:0] err;
    logic       pass;
    logic       tmo;
  } result_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] tx_q[$];
  result_t    res_q[$];
  int         mode[NB];
  logic [7:0] corrupt_val[NB];
  int         resp_idx = 0;
  int         sent_cnt = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference pattern: the k-th byte of a run, computed from the sequence definition.
  function automatic logic [7:0] model_pattern(input int k);
    logic [7:0] p;
`ifdef UART_BIST_LFSR_EN
    p = 8'h01;
    for (int i = 0; i < k; i++) p = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
`else
    p = 8'(k % 256);
`endif
    return p;
  endfunction

  // Monitor: pops expectations whenever the DUT transmits or completes a run.
  logic       done_q = 1'b0;
  logic [7:0] exp_tx = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      done_q = 1'b0;
      exp_tx = 8'h00;
    end else begin
      if (tx_start) begin
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL tx_unexpected: got tx_start with data %0h, expected no transmit", tx_data);
        end else begin
          exp_tx = tx_q.pop_front();
          checkOutput("tx_data", int'(tx_data), int'(exp_tx));
        end
      end else begin
        checkOutput("tx_data_stable", int'(tx_data), int'(exp_tx));
      end
      if (done && !done_q) begin
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL done_unexpected: got done=1, expected no completion");
        end else begin
          result_t r;
          r = res_q.pop_front();
          checkOutput("err_count", int'(err_count), int'(r.err));
          checkOutput("pass", int'(pass), int'(r.pass));
          checkOutput("timeout_err", int'(timeout_err), int'(r.tmo));
          checkOutput("busy_at_done", int'(busy), 0);
        end
      end
      done_q = done;
    end
  end

  // Loopback responder: echoes each transmitted byte according to its per-byte mode.
  int         cnt = 0;
  bit         drop_cur = 1'b0;
  bit         garbage = 1'b0;
  bit         garb_pend = 1'b0;
  logic [7:0] reply = 8'h00;
  always @(negedge clk) begin
    rx_done = 1'b0;
    if (!rst_n) begin
      cnt       = 0;
      resp_busy = 1'b0;
      garbage   = 1'b0;
      garb_pend = 1'b0;
    end else begin
      if (garbage) begin
        rx_done = 1'b1;
        rx_data = 8'($urandom);
        garbage = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          resp_busy = 1'b0;
          if (!drop_cur) begin
            rx_done = 1'b1;
            rx_data = reply;
            garbage = garb_pend;
          end
        end
      end
      if (tx_start) begin
        int m;
        m         = (resp_idx < NB) ? mode[resp_idx] : M_GOOD;
        reply     = tx_data;
        drop_cur  = 1'b0;
        garb_pend = 1'b0;
        resp_busy = 1'b1;
        case (m)
          M_CORRUPT: begin
            cnt   = int'($urandom_range(1, 10));
            reply = corrupt_val[resp_idx];
          end
          M_DROP: begin
            cnt      = int'($urandom_range(1, 10));
            drop_cur = 1'b1;
          end
          M_EDGE:  cnt = TO - 1;
          M_LATE:  cnt = TO;
          default: begin
            cnt       = int'($urandom_range(1, 10));
            garb_pend = ($urandom_range(0, 1) == 1);
          end
        endcase
        resp_idx++;
        sent_cnt++;
      end
    end
  end

  task automatic setModes(input int m0, input int m1, input int m2, input int m3);
    mode[0] = m0;
    mode[1] = m1;
    mode[2] = m2;
    mode[3] = m3;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("run_done", int'(done), 1);
    repeat (3) @(negedge clk);
    checkOutput("done_hold", int'(done), 1);
    checkOutput("busy_idle", int'(busy), 0);
  endtask

  // Pushes the model's expected byte stream and final result, then launches a run.
  task automatic applyStimulus(input bit restart_mid);
    int      e = 0;
    bit      t = 1'b0;
    result_t r;
    int      n = 0;
    for (int i = 0; i < NB; i++) begin
      tx_q.push_back(model_pattern(i));
      case (mode[i])
        M_CORRUPT: if (corrupt_val[i] != model_pattern(i)) e++;
        M_DROP, M_LATE: begin
          e++;
          t = 1'b1;
        end
        default: ;
      endcase
    end
    r.err  = 8'((e > 255) ? 255 : e);
    r.pass = (e == 0);
    r.tmo  = t;
    res_q.push_back(r);
    resp_idx = 0;
    sent_cnt = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (restart_mid) begin
      while (sent_cnt < 1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    waitDone(400);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < NB; i++) begin
      mode[i]        = M_GOOD;
      corrupt_val[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_tx_start", int'(tx_start), 0);
    checkOutput("rst_tx_data", int'(tx_data), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_pass", int'(pass), 0);
    checkOutput("rst_err", int'(err_count), 0);
    checkOutput("rst_tmo", int'(timeout_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] clean run");
    setModes(M_GOOD, M_GOOD, M_GOOD, M_GOOD);
    applyStimulus(1'b0);

    $display("[TB] byte 2 echoed as FF");
    setModes(M_GOOD, M_GOOD, M_CORRUPT, M_GOOD);
    corrupt_val[2] = 8'hFF;
    applyStimulus(1'b0);

    $display("[TB] byte 1 echo suppressed");
    setModes(M_GOOD, M_DROP, M_GOOD, M_GOOD);
    applyStimulus(1'b0);

    $display("[TB] echo on the last timer cycle, then one cycle too late");
    setModes(M_EDGE, M_GOOD, M_GOOD, M_LATE);
    applyStimulus(1'b0);

    $display("[TB] start pulsed mid-run");
    setModes(M_GOOD, M_GOOD, M_GOOD, M_GOOD);
    applyStimulus(1'b1);

    $display("[TB] randomized runs");
    for (int run = 0; run < 12; run++) begin
      for (int i = 0; i < NB; i++) begin
        mode[i] = int'($urandom_range(0, 4));
        corrupt_val[i] = ($urandom_range(0, 3) == 0) ? model_pattern(i) : 8'($urandom);
      end
      applyStimulus(run[0]);
    end

    $display("[TB] abort in WAIT_RX of byte 2");
    begin
      int n = 0;
      setModes(M_CORRUPT, M_GOOD, M_GOOD, M_GOOD);
      corrupt_val[0] = model_pattern(0) ^ 8'h5A;
      for (int i = 0; i < 3; i++) tx_q.push_back(model_pattern(i));
      resp_idx = 0;
      sent_cnt = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      while (sent_cnt < 3 && n < 400) begin
        @(negedge clk);
        n++;
      end
      checkOutput("abort_reached_byte2", sent_cnt, 3);
      abort = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_done", int'(done), 0);
      checkOutput("abort_tx_start", int'(tx_start), 0);
      checkOutput("abort_err_hold", int'(err_count), 1);
      @(negedge clk) abort = 1'b0;
      repeat (15) @(negedge clk);
      checkOutput("abort_stays_idle", int'(busy), 0);
      checkOutput("abort_txq_empty", tx_q.size(), 0);
    end
    setModes(M_GOOD, M_GOOD, M_GOOD, M_GOOD);
    applyStimulus(1'b0);

    $display("[TB] reset while held in SEND");
    hold_busy = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("send_hold_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_tx_start", int'(tx_start), 0);
    checkOutput("midrst_tx_data", int'(tx_data), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_pass", int'(pass), 0);
    checkOutput("midrst_err", int'(err_count), 0);
    checkOutput("midrst_tmo", int'(timeout_err), 0);
    repeat (2) @(negedge clk);
    hold_busy = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("post_rst_idle", int'(busy), 0);
    applyStimulus(1'b0);

    $display("[TB] saturation with 256 timeouts");
    begin
      int n = 0;
      @(negedge clk) sat_start = 1'b1;
      @(negedge clk) sat_start = 1'b0;
      while (!sat_done && n < 4000) begin
        @(negedge clk);
        n++;
      end
      checkOutput("sat_done", int'(sat_done), 1);
      checkOutput("sat_err", int'(sat_err_count), 255);
      checkOutput("sat_pass", int'(sat_pass), 0);
      checkOutput("sat_tmo", int'(sat_timeout_err), 1);
    end

    checkOutput("txq_drained", tx_q.size(), 0);
    checkOutput("resq_drained", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
